// File: rtl/ppupal_pkg.sv
// ppupal_pkg: shared constants, types and helpers for the final PPU pixel stage.
//   - ppumask ($2001) bit positions
//   - palette colour width and pixel pipeline latency
//   - stage-1 pipeline record
//   - palette address mirror helper
package ppupal_pkg;

  // Colour width of one palette RAM entry (NES colour index).
  localparam int COLW    = 6;
  // Ticks from dot sample to pix/pixvalid.
  localparam int LATENCY = 2;

  // $2001 bit positions.
  localparam int MASK_GREY    = 0;
  localparam int MASK_BGLEFT  = 1;
  localparam int MASK_SPRLEFT = 2;
  localparam int MASK_BGEN    = 3;
  localparam int MASK_SPREN   = 4;
  localparam int MASK_EMPH_LO = 5;

  // What stage 1 remembers about a sampled dot until its colour returns from RAM.
  typedef struct packed {
    logic       valid;
    logic [7:0] x;
    logic [7:0] y;
    logic       grey;
    logic [2:0] emph;
  } s1_t;

  // Entries $10/$14/$18/$1C are the same cells as $00/$04/$08/$0C.
  function automatic logic [4:0] pal_mirror(input logic [4:0] a);
    logic [4:0] m;
    if (a[1:0] == 2'b00) begin
      m = {1'b0, a[3:0]};
    end else begin
      m = a;
    end
    return m;
  endfunction

endpackage

// File: rtl/ppupal_ram.sv
// ppupalram: 32 x 6-bit palette RAM, one synchronous read port and one write port.
// Address mirroring is the caller's job.
//   clk    in   system clock
//   re     in   read enable; rdata updates only when set
//   raddr  in   read address
//   rdata  out  registered read data (read-first w.r.t. a same-cycle write)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
module ppupalram
  import ppupal_pkg::*;
(
  input  logic            clk,
  input  logic            re,
  input  logic [4:0]      raddr,
  output logic [COLW-1:0] rdata,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [COLW-1:0] wdata
);

  logic [COLW-1:0] mem_q [0:31];
  logic [COLW-1:0] rdata_q;

  // Storage and registered read; the read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ppupal.sv
// ppupal: final PPU pixel stage. Merges background and sprite pixels, resolves
// priority and sprite-0 hit, looks the result up in the palette RAM and emits
// one coloured pixel per visible dot. Also services CPU $2007 palette access.
//   clk, reset           clock, synchronous active-high reset
//   tick                 dot enable; state advances only when set
//   ppux, ppuy           current dot / line
//   render               rendering enabled
//   ppumask              $2001 copy
//   bgpix, sprpix        {palette, colour} from background / sprite units
//   sprprio, sprzero     sprite behind bg / sprite is OAM sprite 0
//   upalacc, upaladdr    v points at palette space, v[4:0]
//   regwdata             CPU write data
//   wr2007, rd2007       CPU $2007 write / read
//   paldata              {2'b00, entry} for palette reads
//   spr0hit              $2002 bit 6
//   pix, pixvalid        {emphasis, colour}, one-clk strobe
//   pixx, pixy           screen position of pix
module ppupal
  import ppupal_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [8:0] ppux,
  input  logic [8:0] ppuy,
  input  logic       render,
  input  logic [7:0] ppumask,
  input  logic [3:0] bgpix,
  input  logic [3:0] sprpix,
  input  logic       sprprio,
  input  logic       sprzero,
  input  logic       upalacc,
  input  logic [4:0] upaladdr,
  input  logic [7:0] regwdata,
  input  logic       wr2007,
  input  logic       rd2007,
  output logic [7:0] paldata,
  output logic       spr0hit,
  output logic [8:0] pix,
  output logic       pixvalid,
  output logic [7:0] pixx,
  output logic [7:0] pixy
);

  logic            in_win_s;
  logic [8:0]      col9_s;
  logic [7:0]      col_s;
  logic            bgo_s;
  logic            spo_s;
  logic [4:0]      prio_idx_s;
  logic [4:0]      pix_idx_s;
  logic [4:0]      cpu_addr_s;
  logic [4:0]      raddr_s;
  logic            wr_s;
  logic            rd_s;
  logic [COLW-1:0] ram_rdata_s;
  logic [COLW-1:0] col_out_s;
  logic            unused_ok;

  s1_t        s1_d, s1_q;
  logic       spr0hit_d, spr0hit_q;
  logic       pixvalid_d, pixvalid_q;
  logic       rd_pend_d, rd_pend_q;
  logic [8:0] pix_d, pix_q;
  logic [7:0] pixx_d, pixx_q;
  logic [7:0] pixy_d, pixy_q;
  logic [7:0] paldata_d, paldata_q;

  assign unused_ok = ^{regwdata[7:6], col9_s[8]};

  // Dot window, left-clip/opacity and background/sprite priority.
  always_comb begin
    in_win_s   = (ppuy < 9'd240) && (ppux >= 9'd2) && (ppux <= 9'd257);
    col9_s     = ppux - 9'd2;
    col_s      = col9_s[7:0];
    bgo_s      = (bgpix[1:0] != 2'b00) && ppumask[MASK_BGEN] &&
                 ((col_s >= 8'd8) || ppumask[MASK_BGLEFT]);
    spo_s      = (sprpix[1:0] != 2'b00) && ppumask[MASK_SPREN] &&
                 ((col_s >= 8'd8) || ppumask[MASK_SPRLEFT]);
    prio_idx_s = 5'h00;
    if (spo_s && (!sprprio || !bgo_s)) begin
      prio_idx_s = {1'b1, sprpix};
    end else if (bgo_s) begin
      prio_idx_s = {1'b0, bgpix};
    end else begin
      prio_idx_s = 5'h00;
    end
    // With rendering off the pixel shows the entry v points at (or the backdrop).
    if (render) begin
      pix_idx_s = prio_idx_s;
    end else if (upalacc) begin
      pix_idx_s = upaladdr;
    end else begin
      pix_idx_s = 5'h00;
    end
  end

  // CPU access decode and RAM read-port arbitration. A rendering dot owns the
  // port; otherwise a CPU read uses it. With render off the two addresses match.
  always_comb begin
    cpu_addr_s = pal_mirror(upaladdr);
    wr_s       = tick && wr2007 && upalacc;
    rd_s       = tick && rd2007 && upalacc && !wr2007;
    if (in_win_s && render) begin
      raddr_s = pal_mirror(pix_idx_s);
    end else if (rd_s) begin
      raddr_s = cpu_addr_s;
    end else begin
      raddr_s = pal_mirror(pix_idx_s);
    end
  end

  ppupalram u_ram (
    .clk   (clk),
    .re    (tick),
    .raddr (raddr_s),
    .rdata (ram_rdata_s),
    .we    (wr_s),
    .waddr (cpu_addr_s),
    .wdata (regwdata[5:0])
  );

  // Stage-1 record, sprite-0 hit and output stage next-state.
  always_comb begin
    s1_d       = s1_q;
    spr0hit_d  = spr0hit_q;
    pixvalid_d = 1'b0;
    pix_d      = pix_q;
    pixx_d     = pixx_q;
    pixy_d     = pixy_q;
    rd_pend_d  = rd_s;
    col_out_s  = ram_rdata_s;
    if (s1_q.grey) begin
      col_out_s = ram_rdata_s & 6'h30;
    end else begin
      col_out_s = ram_rdata_s;
    end
    if (tick) begin
      s1_d.valid = in_win_s;
      s1_d.x     = col_s;
      s1_d.y     = ppuy[7:0];
      s1_d.grey  = ppumask[MASK_GREY];
      s1_d.emph  = ppumask[7:MASK_EMPH_LO];
      if ((ppuy == 9'd261) && (ppux == 9'd1)) begin
        spr0hit_d = 1'b0;
      end else if (in_win_s && bgo_s && spo_s && sprzero && (col_s != 8'd255)) begin
        spr0hit_d = 1'b1;
      end else begin
        spr0hit_d = spr0hit_q;
      end
      if (s1_q.valid) begin
        pixvalid_d = 1'b1;
        pix_d      = {s1_q.emph, col_out_s};
        pixx_d     = s1_q.x;
        pixy_d     = s1_q.y;
      end else begin
        pixvalid_d = 1'b0;
      end
    end else begin
      pixvalid_d = 1'b0;
    end
    // Read data lands in the RAM register at the read tick; capture it one clk later.
    if (rd_pend_q) begin
      paldata_d = {2'b00, ram_rdata_s};
    end else begin
      paldata_d = paldata_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= '0;
      spr0hit_q  <= 1'b0;
      pixvalid_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      pix_q      <= 9'd0;
      pixx_q     <= 8'd0;
      pixy_q     <= 8'd0;
      paldata_q  <= 8'd0;
    end else begin
      s1_q       <= s1_d;
      spr0hit_q  <= spr0hit_d;
      pixvalid_q <= pixvalid_d;
      rd_pend_q  <= rd_pend_d;
      pix_q      <= pix_d;
      pixx_q     <= pixx_d;
      pixy_q     <= pixy_d;
      paldata_q  <= paldata_d;
    end
  end

  assign paldata  = paldata_q;
  assign spr0hit  = spr0hit_q;
  assign pix      = pix_q;
  assign pixvalid = pixvalid_q;
  assign pixx     = pixx_q;
  assign pixy     = pixy_q;

endmodule
